// File: rtl/sprite_line_renderer.sv
// sprite_line_renderer: scans the object table per scanline and draws sprite entries into a ping-pong line buffer.
// Optional SPRITE_LINE_REL_EN appends rel_y/rel_x to each buffer entry.
module sprite_line_renderer #(
  parameter int MAX_OBJECTS  = 20,
  parameter int MAX_PER_LINE = 8,
  parameter int SPRITE_W     = 16,
  parameter int LINE_W       = 640
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        line_start,
  input  logic [9:0]  line_y,
  output logic [4:0]  obj_rd_idx,
  input  logic [31:0] obj_rd_data,
  input  logic [9:0]  rd_x,
`ifdef SPRITE_LINE_REL_EN
  output logic [19:0] rd_data,
`else
  output logic [11:0] rd_data,
`endif
  output logic        busy,
  output logic        overflow,
  output logic        late
);
`ifdef SPRITE_LINE_REL_EN
  localparam int ENTRY_W = 20;
`else
  localparam int ENTRY_W = 12;
`endif
  localparam int SW = $clog2(MAX_PER_LINE);
  typedef enum logic [1:0] {IDLE, CLEAR, SCAN, DRAW} state_t;
  state_t state, state_n;
  logic [ENTRY_W-1:0] mem [2][LINE_W];
  logic [4:0]  st_idx [MAX_PER_LINE];
  logic [11:0] st_x   [MAX_PER_LINE];
  logic [5:0]  st_spr [MAX_PER_LINE];
  logic [3:0]  st_rel [MAX_PER_LINE];
  logic [9:0]  ly, cnt, wa;
  logic [4:0]  sc;
  logic [3:0]  hit_cnt, k;
  logic [SW-1:0] top;
  logic [11:0] oy, dy;
  logic [12:0] col;
  logic [ENTRY_W-1:0] wdata;
  logic disp_bank, first_done, shown, hit, push, fin, we, unused_rsvd;
  assign unused_rsvd = obj_rd_data[0];
  always_comb begin
    oy = obj_rd_data[19:8];
    dy = {2'b0, ly} - oy;
    hit = state == SCAN && sc != 5'd0 && obj_rd_data[1] && oy <= {2'b0, ly} && dy < 12'(SPRITE_W);
    push = hit && hit_cnt < 4'(MAX_PER_LINE);
    obj_rd_idx = sc < 5'(MAX_OBJECTS) ? sc : 5'(MAX_OBJECTS - 1);
    top = SW'(hit_cnt - 4'd1);
    col = {1'b0, st_x[top]} + 13'(k);
    fin = state == DRAW && (hit_cnt == 4'd0 || (hit_cnt == 4'd1 && k == 4'(SPRITE_W - 1)));
    we = state == CLEAR || (state == DRAW && hit_cnt != 4'd0 && col < 13'(LINE_W));
    wa = state == CLEAR ? cnt : col[9:0];
`ifdef SPRITE_LINE_REL_EN
    wdata = state == CLEAR ? '0 : {1'b1, st_spr[top], st_idx[top], st_rel[top], k};
`else
    wdata = state == CLEAR ? '0 : {1'b1, st_spr[top], st_idx[top]};
`endif
    busy = state != IDLE;
  end
  // Any line_start restarts the clear; abort vs. swap is decided in the datapath.
  always_comb begin
    state_n = line_start ? CLEAR :
              (state == CLEAR && cnt == 10'(LINE_W - 1)) ? SCAN :
              (state == SCAN && sc == 5'(MAX_OBJECTS)) ? DRAW :
              fin ? IDLE : state;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ly <= '0;
      cnt <= '0;
      sc <= '0;
      k <= '0;
      hit_cnt <= '0;
      disp_bank <= 1'b0;
      first_done <= 1'b0;
      shown <= 1'b0;
      overflow <= 1'b0;
      late <= 1'b0;
      rd_data <= '0;
    end else begin
      cnt <= (state_n == CLEAR && !line_start) ? cnt + 10'd1 : '0;
      sc <= (state_n == SCAN && state == SCAN) ? sc + 5'd1 : '0;
      k <= (state == DRAW && hit_cnt != 4'd0 && !line_start) ? k + 4'd1 : '0;
      if (line_start) begin
        ly <= line_y;
        hit_cnt <= '0;
      end else if (push) hit_cnt <= hit_cnt + 4'd1;
      else if (state == DRAW && hit_cnt != 4'd0 && k == 4'(SPRITE_W - 1)) hit_cnt <= hit_cnt - 4'd1;
      if (hit && !push) overflow <= 1'b1;
      if (line_start && busy && !fin) late <= 1'b1;
      if (fin) first_done <= 1'b1;
      // A render finishing in the same cycle as line_start still counts toward the swap.
      if (line_start && (state == IDLE || fin) && (first_done || fin)) begin
        disp_bank <= ~disp_bank;
        shown <= 1'b1;
      end
      rd_data <= (shown && rd_x < 10'(LINE_W)) ? mem[disp_bank][rd_x] : '0;
    end
  end
  always_ff @(posedge clk) begin
    if (we) mem[~disp_bank][wa] <= wdata;
    if (push) begin
      st_idx[hit_cnt[SW-1:0]] <= sc - 5'd1;
      st_x[hit_cnt[SW-1:0]] <= obj_rd_data[31:20];
      st_spr[hit_cnt[SW-1:0]] <= obj_rd_data[7:2];
      st_rel[hit_cnt[SW-1:0]] <= dy[3:0];
    end
  end
endmodule

// File: tb/tb_sprite_line_renderer.sv
// tb_sprite_line_renderer: directed checks of the scanline sprite renderer against hand-computed entries.
module tb_sprite_line_renderer;
`ifdef SPRITE_LINE_REL_EN
  localparam int ENTRY_W = 20;
`else
  localparam int ENTRY_W = 12;
`endif
  logic clk = 1'b0, reset_n = 1'b0, line_start = 1'b0;
  logic [9:0] line_y = '0, rd_x = '0;
  logic [4:0] obj_rd_idx;
  logic [31:0] obj_rd_data = '0;
  logic [ENTRY_W-1:0] rd_data;
  logic busy, overflow, late;
  logic [31:0] tbl [20];
  int errors = 0, checks = 0;
  sprite_line_renderer dut (
    .clk(clk), .reset_n(reset_n), .line_start(line_start), .line_y(line_y),
    .obj_rd_idx(obj_rd_idx), .obj_rd_data(obj_rd_data), .rd_x(rd_x),
    .rd_data(rd_data), .busy(busy), .overflow(overflow), .late(late)
  );
  always #10 clk = ~clk;
  always @(posedge clk) obj_rd_data <= tbl[obj_rd_idx];
  function automatic logic [31:0] ent(input int spr, input int id, input int ry, input int rx);
`ifdef SPRITE_LINE_REL_EN
    return {12'b0, 1'b1, 6'(spr), 5'(id), 4'(ry), 4'(rx)};
`else
    return {20'b0, 1'b1, 6'(spr), 5'(id)};
`endif
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic set_obj(input int i, input int x, input int y, input int spr, input logic act);
    tbl[i] = {12'(x), 12'(y), 6'(spr), act, 1'b0};
  endtask
  task automatic clr_tbl();
    for (int i = 0; i < 20; i++) tbl[i] = '0;
  endtask
  task automatic pulse(input int y);
    @(negedge clk);
    line_start = 1'b1;
    line_y = 10'(y);
    @(negedge clk);
    line_start = 1'b0;
  endtask
  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(busy), 32'd0);
  endtask
  task automatic chk_col(input string tag, input int x, input logic [31:0] exp);
    @(negedge clk);
    rd_x = 10'(x);
    @(negedge clk);
    chk(tag, 32'(rd_data), exp);
  endtask
  initial begin
    clr_tbl();
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_overflow", 32'(overflow), 0);
    chk("rst_late", 32'(late), 0);
    chk("rst_idx", 32'(obj_rd_idx), 0);
    chk("rst_rd_data", 32'(rd_data), 0);
    reset_n = 1'b1;
    // single sprite, shown only after the following line_start swaps banks
    set_obj(0, 200, 240, 0, 1'b1);
    pulse(245);
    chk("busy_after_start", 32'(busy), 1);
    wait_idle("idle_t1");
    chk_col("no_swap_yet", 200, 0);
    pulse(0);
    chk_col("t1_c199", 199, 0);
    chk_col("t1_c200", 200, ent(0, 0, 5, 0));
    chk_col("t1_c215", 215, ent(0, 0, 5, 15));
    chk_col("t1_c216", 216, 0);
    wait_idle("idle_t1b");
    // overlap: lowest object index wins
    clr_tbl();
    set_obj(0, 100, 300, 5, 1'b1);
    set_obj(1, 108, 296, 9, 1'b1);
    pulse(305);
    wait_idle("idle_t2");
    pulse(0);
    chk_col("t2_c99", 99, 0);
    chk_col("t2_c100", 100, ent(5, 0, 5, 0));
    chk_col("t2_c108", 108, ent(5, 0, 5, 8));
    chk_col("t2_c115", 115, ent(5, 0, 5, 15));
    chk_col("t2_c116", 116, ent(9, 1, 9, 8));
    chk_col("t2_c123", 123, ent(9, 1, 9, 15));
    chk_col("t2_c124", 124, 0);
    wait_idle("idle_t2b");
    // ten hits on one line: eight drawn, overflow latched
    clr_tbl();
    for (int i = 0; i < 10; i++) set_obj(i, i * 40, 45, i + 1, 1'b1);
    chk("ovf_before", 32'(overflow), 0);
    pulse(50);
    wait_idle("idle_t3");
    chk("ovf_after", 32'(overflow), 1);
    pulse(0);
    for (int i = 0; i < 10; i++)
      chk_col($sformatf("t3_obj%0d", i), i * 40 + 3, i < 8 ? ent(i + 1, i, 5, 3) : 32'd0);
    wait_idle("idle_t3b");
    // right edge clipping and vertical hit bounds
    clr_tbl();
    set_obj(3, 630, 100, 7, 1'b1);
    set_obj(4, 300, 85, 2, 1'b1);
    set_obj(5, 400, 84, 4, 1'b1);
    set_obj(6, 500, 101, 11, 1'b1);
    set_obj(7, 550, 100, 13, 1'b0);
    pulse(100);
    wait_idle("idle_t4");
    pulse(0);
    chk_col("t4_c630", 630, ent(7, 3, 0, 0));
    chk_col("t4_c639", 639, ent(7, 3, 0, 9));
    chk_col("t4_c0", 0, 0);
    chk_col("t4_c5", 5, 0);
    chk_col("t4_dy15", 300, ent(2, 4, 15, 0));
    chk_col("t4_dy16", 400, 0);
    chk_col("t4_below", 500, 0);
    chk_col("t4_inactive", 550, 0);
    chk_col("t4_rdx_oob", 700, 0);
    wait_idle("idle_t4b");
    // late line_start: no swap, restart with the new line
    pulse(100);
    repeat (100) @(negedge clk);
    chk("late_before", 32'(late), 0);
    chk("busy_before_late", 32'(busy), 1);
    pulse(101);
    chk("late_set", 32'(late), 1);
    chk_col("late_no_swap", 630, 0);
    wait_idle("idle_t5");
    pulse(0);
    chk_col("t5_c500", 500, ent(11, 6, 0, 0));
    chk_col("t5_c300", 300, 0);
    chk_col("t5_c630", 630, ent(7, 3, 1, 0));
    chk("late_sticky", 32'(late), 1);
    wait_idle("idle_t5b");
    // reset in the middle of DRAW
    pulse(100);
    repeat (670) @(negedge clk);
    chk("busy_mid_draw", 32'(busy), 1);
    reset_n = 1'b0;
    #1;
    chk("rst_mid_busy", 32'(busy), 0);
    chk("rst_mid_rd", 32'(rd_data), 0);
    chk("rst_mid_late", 32'(late), 0);
    chk("rst_mid_ovf", 32'(overflow), 0);
    @(negedge clk);
    reset_n = 1'b1;
    pulse(100);
    wait_idle("idle_t6");
    chk_col("t6_no_swap", 630, 0);
    pulse(0);
    chk_col("t6_swap", 630, ent(7, 3, 0, 0));
    wait_idle("idle_t6b");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
